muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer with architectural HI/LO registers for the MIPS EX stage. It accepts mult/multu/div/divu from the decoded `FUNC_MUL`/`FUNC_DIV` ops. Signedness comes from `OPER_ALUS`/`OPER_ALUU`. While an operation runs, the block stalls the pipeline, then commits HI/LO. It also services mthi/mtlo, and flushes on exception or eret.

---
 rtl/muldiv_ctrl.sv | 155 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO registers.
// Stalls EX while a mult/div runs, then commits the result to HI/LO in DONE.
module muldiv_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_div,
    input  logic        is_sign,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] opa_q, opb_q;
    logic        sign_q;
    logic        quo_neg_q, rem_neg_q;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic [31:0] res_hi_q, res_lo_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q;

    // Sign- or zero-extending to 64 bits makes one truncated multiply serve both cases.
    logic [63:0] ext_a, ext_b, prod;
    assign ext_a = sign_q ? {{32{opa_q[31]}}, opa_q} : {32'b0, opa_q};
    assign ext_b = sign_q ? {{32{opb_q[31]}}, opb_q} : {32'b0, opb_q};
    assign prod  = ext_a * ext_b;

    logic [31:0] abs_a, abs_b;
    assign abs_a = (is_sign && opa[31]) ? (32'd0 - opa) : opa;
    assign abs_b = (is_sign && opb[31]) ? (32'd0 - opb) : opb;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [32:0] shifted, diff;
    logic [31:0] rem_nxt, quo_nxt, quo_fix, rem_fix;
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign rem_nxt = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_nxt = {quo_q[30:0], ~diff[32]};
    assign quo_fix = quo_neg_q ? (32'd0 - quo_nxt) : quo_nxt;
    assign rem_fix = rem_neg_q ? (32'd0 - rem_nxt) : rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            sign_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (flush) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            opa_q     <= opa;
                            opb_q     <= opb;
                            sign_q    <= is_sign;
                            quo_neg_q <= is_sign & (opa[31] ^ opb[31]);
                            rem_neg_q <= is_sign & opa[31];
                            rem_q     <= '0;
                            quo_q     <= abs_a;
                            dvs_q     <= abs_b;
                            cnt_q     <= '0;
                            if (is_div && opb == 32'd0) begin
                                // Divide-by-zero recommits the current HI/LO.
                                res_hi_q <= hi_q;
                                res_lo_q <= lo_q;
                                state_q  <= S_DONE;
                                busy_q   <= 1'b0;
                            end else if (is_div) begin
                                state_q <= S_DIV;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= S_MUL;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    S_MUL: begin
                        if (cnt_q == 6'(MUL_LAT - 1)) begin
                            res_hi_q <= prod[63:32];
                            res_lo_q <= prod[31:0];
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                    S_DIV: begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        if (cnt_q == 6'(DIV_ITER - 1)) begin
                            res_hi_q <= rem_fix;
                            res_lo_q <= quo_fix;
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end

            if (wr_hi && !flush) hi_q <= wdata;
            if (wr_lo && !flush) lo_q <= wdata;
            // Later assignment gives the DONE commit priority over mthi/mtlo.
            if (state_q == S_DONE && !flush) begin
                hi_q <= res_hi_q;
                lo_q <= res_lo_q;
            end
        end
    end

    assign stall = ~flush & ((state_q == S_IDLE && start) ||
                             state_q == S_MUL || state_q == S_DIV);
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: mult/div latency, results, flush, mthi/mtlo, reset.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_div = 1'b0;
    logic        is_sign = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        flush = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        stall, busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;

    muldiv_ctrl #(.MUL_LAT(2), .DIV_ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_div(is_div), .is_sign(is_sign),
        .opa(opa), .opb(opb), .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .wdata(wdata), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Drives an op (called just after a falling edge) and counts stall cycles.
    // Returns in the first non-stalled cycle, i.e. DONE; n_stall saturates at 40.
    task automatic issue_op(input logic d, input logic s, input logic [31:0] a,
                            input logic [31:0] b, output int n_stall, output logic busy1);
        start = 1'b1; is_div = d; is_sign = s; opa = a; opb = b;
        n_stall = 0;
        busy1 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c == 1) busy1 = busy;
            if (!stall) break;
            n_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        $display("reset: hi=%h lo=%h busy=%b stall=%b", hi, lo, busy, stall);
        @(negedge clk);
    endtask

    task automatic test_signed_mult;
        int n; logic b1;
        issue_op(1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, n, b1);
        total++; if (n !== 3) begin bad++; $display("FAIL mult_stall got=%0d want=3", n); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL mult_busy got=%b want=1", b1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_done got=%b want=0", busy); end
        start = 1'b0;
        @(negedge clk); #1;
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h want=fffffffa", lo); end
        $display("mult fffffffe*3: stall=%0d hi=%h lo=%h", n, hi, lo);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n; logic b1;
        issue_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, n, b1);
        total++; if (n !== 3) begin bad++; $display("FAIL multu1_stall got=%0d want=3", n); end
        // start stays high through DONE with the next op's operands
        opa = 32'd2; opb = 32'd3;
        @(negedge clk); #1;
        total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu1_hi got=%h want=fffffffe", hi); end
        total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu1_lo got=%h want=00000001", lo); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", stall); end
        $display("multu ffffffff^2: hi=%h lo=%h", hi, lo);
        issue_op(1'b0, 1'b0, 32'd2, 32'd3, n, b1);
        total++; if (n !== 3) begin bad++; $display("FAIL multu2_stall got=%0d want=3", n); end
        start = 1'b0;
        @(negedge clk); #1;
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL multu2_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd6) begin bad++; $display("FAIL multu2_lo got=%h want=6", lo); end
        $display("multu 2*3: hi=%h lo=%h", hi, lo);
        @(negedge clk);
    endtask

    task automatic test_div;
        // {signed, a, b, expected hi, expected lo}
        logic [127:0] vec [4];
        logic         sgn [4];
        int n; logic b1;
        vec[0] = {32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD}; sgn[0] = 1'b1;
        vec[1] = {32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}; sgn[1] = 1'b1;
        vec[2] = {32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD}; sgn[2] = 1'b1;
        vec[3] = {32'd100,      32'd7,         32'd2,        32'd14};       sgn[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_op(1'b1, sgn[i], vec[i][127:96], vec[i][95:64], n, b1);
            total++; if (n !== 33) begin bad++; $display("FAIL div%0d_stall got=%0d want=33", i, n); end
            total++; if (b1 !== 1'b1) begin bad++; $display("FAIL div%0d_busy got=%b want=1", i, b1); end
            start = 1'b0;
            @(negedge clk); #1;
            total++; if (hi !== vec[i][63:32]) begin bad++; $display("FAIL div%0d_hi got=%h want=%h", i, hi, vec[i][63:32]); end
            total++; if (lo !== vec[i][31:0]) begin bad++; $display("FAIL div%0d_lo got=%h want=%h", i, lo, vec[i][31:0]); end
            $display("div s=%b %h/%h: stall=%0d hi=%h lo=%h", sgn[i], vec[i][127:96], vec[i][95:64], n, hi, lo);
            @(negedge clk);
        end
    endtask

    task automatic test_div_by_zero;
        int n; logic b1;
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0; wdata = 32'h5678;
        @(negedge clk);
        wr_lo = 1'b0;
        #1;
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mt_hi got=%h want=1234", hi); end
        total++; if (lo !== 32'h5678) begin bad++; $display("FAIL mt_lo got=%h want=5678", lo); end
        @(negedge clk);
        issue_op(1'b1, 1'b0, 32'd55, 32'd0, n, b1);
        total++; if (n !== 1) begin bad++; $display("FAIL dz_stall got=%0d want=1", n); end
        start = 1'b0;
        @(negedge clk); #1;
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL dz_hi got=%h want=1234", hi); end
        total++; if (lo !== 32'h5678) begin bad++; $display("FAIL dz_lo got=%h want=5678", lo); end
        $display("divu 55/0: stall=%0d hi=%h lo=%h", n, hi, lo);
        @(negedge clk);
    endtask

    task automatic test_flush;
        int n; logic b1;
        start = 1'b1; is_div = 1'b1; is_sign = 1'b0; opa = 32'd1000; opb = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
        total++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            bad++; $display("FAIL flush_hilo got=%h/%h want=1234/5678", hi, lo);
        end
        $display("flush at div cycle 10: hi=%h lo=%h busy=%b", hi, lo, busy);
        issue_op(1'b0, 1'b0, 32'd5, 32'd6, n, b1);
        total++; if (n !== 3) begin bad++; $display("FAIL postflush_stall got=%0d want=3", n); end
        start = 1'b0;
        @(negedge clk); #1;
        total++; if (lo !== 32'd30 || hi !== 32'd0) begin
            bad++; $display("FAIL postflush_res got=%h/%h want=0/1e", hi, lo);
        end
        $display("multu 5*6 after flush: hi=%h lo=%h", hi, lo);
        @(negedge clk);
    endtask

    task automatic test_mthi_and_priority;
        int n; logic b1;
        wr_hi = 1'b1; wdata = 32'hCAFE;
        @(negedge clk);
        wr_hi = 1'b0;
        #1;
        total++; if (hi !== 32'hCAFE) begin bad++; $display("FAIL mthi got=%h want=cafe", hi); end
        total++; if (lo !== 32'd30) begin bad++; $display("FAIL mthi_lo got=%h want=1e", lo); end
        $display("mthi cafe: hi=%h lo=%h", hi, lo);
        @(negedge clk);
        issue_op(1'b0, 1'b0, 32'd7, 32'd8, n, b1);
        start = 1'b0;
        wr_lo = 1'b1; wdata = 32'hBEEF;
        @(negedge clk);
        wr_lo = 1'b0;
        #1;
        total++; if (lo !== 32'd56) begin bad++; $display("FAIL commit_wins got=%h want=38", lo); end
        $display("mtlo during DONE of 7*8: lo=%h", lo);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_div;
        start = 1'b1; is_div = 1'b1; is_sign = 1'b1; opa = 32'd99; opb = 32'd4;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        #1;
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL rstdiv_hilo got=%h/%h want=0/0", hi, lo);
        end
        total++; if (busy !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL rstdiv_ctrl got=%b/%b want=0/0", busy, stall);
        end
        $display("reset mid-div: hi=%h lo=%h busy=%b stall=%b", hi, lo, busy, stall);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_signed_mult;
        test_back_to_back;
        test_div;
        test_div_by_zero;
        test_flush;
        test_mthi_and_priority;
        test_reset_mid_div;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
